vend_dispense_arbiter: RTL and testbench

//   Shares one product-dispense motor and one change-return unit between N_LANES

---
 rtl/vend_dispense_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vend_dispense_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_arbiter.sv
// -----------------------------------------------------------------------------
// vend_dispense_arbiter
//   Shares one product-dispense motor and one change-return unit between
//   N_LANES coin-acceptor lanes. Requesting lanes are granted round-robin.
//   The motor is driven for DISPENSE_CYCLES. If the lane owes change, the
//   change unit is then driven for CHANGE_CYCLES. A one-cycle ack completes
//   the service.
//
// Ports
//   clk          in   1             system clock, rising edge
//   reset        in   1             synchronous, active-low reset
//   lane_req     in   N_LANES       lane paid; level, held until ack
//   lane_change  in   N_LANES       lane owes change; valid with lane_req
//   lane_grant   out  N_LANES       one-hot, lane being serviced
//   lane_ack     out  N_LANES       one-cycle pulse, service complete
//   motor_en     out  1             dispense motor drive
//   motor_lane   out  $clog2(N)     lane routed to the motor chute
//   change_en    out  1             change-return drive
//   busy         out  1             high whenever not idle
// -----------------------------------------------------------------------------
module vend_dispense_arbiter #(
    parameter int N_LANES         = 4,
    parameter int DISPENSE_CYCLES = 8,
    parameter int CHANGE_CYCLES   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_LANES-1:0]         lane_req,
    input  logic [N_LANES-1:0]         lane_change,
    output logic [N_LANES-1:0]         lane_grant,
    output logic [N_LANES-1:0]         lane_ack,
    output logic                       motor_en,
    output logic [$clog2(N_LANES)-1:0] motor_lane,
    output logic                       change_en,
    output logic                       busy
);

    localparam int IDX_W   = $clog2(N_LANES);
    localparam int TMR_MAX = (DISPENSE_CYCLES > CHANGE_CYCLES) ? DISPENSE_CYCLES : CHANGE_CYCLES;
    // The timer only ever holds phase length minus one.
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [TMR_W-1:0]   timer_r;
    logic               change_r;

    logic [IDX_W-1:0]   pick_s;
    logic               found_s;

    // One-hot decode of a lane index.
    function automatic logic [N_LANES-1:0] lane_onehot(input logic [IDX_W-1:0] lane);
        logic [N_LANES-1:0] v;
        v = '0;
        v[lane] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first requesting lane scanning from rr_ptr upward, wrapping.
    always_comb begin
        int cand_v;
        pick_s  = rr_ptr_r;
        found_s = 1'b0;
        cand_v  = 0;
        for (int i = 0; i < N_LANES; i++) begin
            cand_v = int'(rr_ptr_r) + i;
            if (cand_v >= N_LANES) begin
                cand_v = cand_v - N_LANES;
            end else begin
                cand_v = cand_v;
            end
            if (!found_s && lane_req[cand_v]) begin
                pick_s  = IDX_W'(cand_v);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Service FSM; every output is registered and changes together with the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            rr_ptr_r   <= '0;
            timer_r    <= '0;
            change_r   <= 1'b0;
            lane_grant <= '0;
            lane_ack   <= '0;
            motor_en   <= 1'b0;
            motor_lane <= '0;
            change_en  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            lane_ack <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        // Request and change flag are latched here; later input
                        // changes do not affect this service.
                        idx_r      <= pick_s;
                        change_r   <= lane_change[pick_s];
                        timer_r    <= TMR_W'(DISPENSE_CYCLES - 1);
                        state_r    <= ST_DISPENSE;
                        motor_en   <= 1'b1;
                        motor_lane <= pick_s;
                        lane_grant <= lane_onehot(pick_s);
                        busy       <= 1'b1;
                    end
                end
                ST_DISPENSE: begin
                    if (timer_r == '0) begin
                        motor_en   <= 1'b0;
                        motor_lane <= '0;
                        if (change_r) begin
                            timer_r   <= TMR_W'(CHANGE_CYCLES - 1);
                            change_en <= 1'b1;
                            state_r   <= ST_CHANGE;
                        end else begin
                            lane_ack <= lane_onehot(idx_r);
                            state_r  <= ST_DONE;
                        end
                    end else begin
                        timer_r <= timer_r - TMR_W'(1);
                    end
                end
                ST_CHANGE: begin
                    if (timer_r == '0) begin
                        change_en <= 1'b0;
                        lane_ack  <= lane_onehot(idx_r);
                        state_r   <= ST_DONE;
                    end else begin
                        timer_r <= timer_r - TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    // Ack is visible this cycle; the following IDLE cycle lets the
                    // requester drop its level before the next arbitration.
                    rr_ptr_r   <= (idx_r == IDX_W'(N_LANES - 1)) ? '0 : idx_r + IDX_W'(1);
                    lane_grant <= '0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    lane_grant <= '0;
                    motor_en   <= 1'b0;
                    motor_lane <= '0;
                    change_en  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vend_dispense_arbiter
//   Directed self-checking bench for vend_dispense_arbiter (4 lanes, 8-cycle
//   dispense, 4-cycle change). Inputs change and outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_vend_dispense_arbiter;

    localparam int N_LANES = 4;
    localparam int DISP    = 8;
    localparam int CHG     = 4;

    logic                 clk;
    logic                 reset;
    logic [N_LANES-1:0]   lane_req;
    logic [N_LANES-1:0]   lane_change;
    logic [N_LANES-1:0]   lane_grant;
    logic [N_LANES-1:0]   lane_ack;
    logic                 motor_en;
    logic [1:0]           motor_lane;
    logic                 change_en;
    logic                 busy;

    int checks_r = 0;
    int errors_r = 0;

    vend_dispense_arbiter #(
        .N_LANES         (N_LANES),
        .DISPENSE_CYCLES (DISP),
        .CHANGE_CYCLES   (CHG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lane_req    (lane_req),
        .lane_change (lane_change),
        .lane_grant  (lane_grant),
        .lane_ack    (lane_ack),
        .motor_en    (motor_en),
        .motor_lane  (motor_lane),
        .change_en   (change_en),
        .busy        (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output bundle {busy, change_en, motor_en, lane_grant, lane_ack}.
    function automatic logic [10:0] out_vec();
        return {busy, change_en, motor_en, lane_grant, lane_ack};
    endfunction

    // Follows one service that starts at the next rising edge. Cycle 1 is the first
    // cycle after the sampling edge. At cycle perturb_c the lane drops its request
    // and inverts its change flag. The request is dropped on the ack cycle. One
    // trailing idle cycle is checked.
    task automatic expect_service(input int lane, input bit chg, input int perturb_c, input string name);
        int          ack_c;
        logic [3:0]  oh;
        logic [10:0] exp_v;
        bit          m_exp;
        bit          c_exp;
        bit          act;
        ack_c = DISP + (chg ? CHG : 0) + 1;
        oh    = 4'b0001 << lane;
        for (int c = 1; c <= ack_c + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            m_exp = (c <= DISP);
            c_exp = chg && (c > DISP) && (c <= DISP + CHG);
            act   = (c <= ack_c);
            exp_v = {act, c_exp, m_exp, (act ? oh : 4'b0000), ((c == ack_c) ? oh : 4'b0000)};
            check_eq($sformatf("%s c%0d outs", name, c), 32'(out_vec()), 32'(exp_v));
            if (m_exp) begin
                check_eq($sformatf("%s c%0d motor_lane", name, c), 32'(motor_lane), 32'(lane));
            end
            if (c == perturb_c) begin
                lane_req[lane]    = 1'b0;
                lane_change[lane] = ~lane_change[lane];
            end
            if (c == ack_c) begin
                lane_req[lane] = 1'b0;
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        lane_req    = 4'b1111;
        lane_change = 4'b0000;

        // T1: reset held low with all lanes requesting.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("T1 c%0d outs", c), 32'(out_vec()), 32'd0);
            check_eq($sformatf("T1 c%0d motor_lane", c), 32'(motor_lane), 32'd0);
        end

        // T2: lane 2 without change.
        reset       = 1'b1;
        lane_req    = 4'b0100;
        lane_change = 4'b0000;
        expect_service(2, 1'b0, 0, "T2");

        // T3: lane 0 with change; ack at cycle 13.
        lane_req    = 4'b0001;
        lane_change = 4'b0001;
        expect_service(0, 1'b1, 0, "T3");

        // T4: fresh pointer, all lanes request; order 0,1,2,3, then wrap to 0.
        lane_change = 4'b0000;
        reset       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset       = 1'b1;
        lane_req    = 4'b1111;
        expect_service(0, 1'b0, 0, "T4 l0");
        expect_service(1, 1'b0, 0, "T4 l1");
        expect_service(2, 1'b0, 0, "T4 l2");
        expect_service(3, 1'b0, 0, "T4 l3");
        lane_req    = 4'b1001;
        expect_service(0, 1'b0, 0, "T4 wrap");
        lane_req    = 4'b0000;

        // T5: reset in cycle 4 of lane 1 dispense aborts without ack.
        lane_req    = 4'b0010;
        lane_change = 4'b0000;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("T5 c%0d outs", c), 32'(out_vec()), 32'({1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000}));
        end
        reset = 1'b0;
        for (int c = 5; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("T5 abort c%0d outs", c), 32'(out_vec()), 32'd0);
        end
        reset = 1'b1;
        expect_service(1, 1'b0, 0, "T5 reserve");
        lane_req = 4'b0000;

        // T6: inputs change mid-dispense; latched values decide the service.
        lane_req    = 4'b1000;
        lane_change = 4'b1000;
        expect_service(3, 1'b1, 3, "T6a");
        lane_req    = 4'b0100;
        lane_change = 4'b0000;
        expect_service(2, 1'b0, 3, "T6b");

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
